// File: rtl/uart_block_tx_if.sv
// rtl/uart_block_tx_if.sv - block handshake between cipher datapath and serial transmitter
// The master presents a block with valid; the slave signals when it can take it.
interface uart_block_tx_if #(
   parameter int NUM_BYTES = 8
);
   logic [8*NUM_BYTES-1:0] block_data;
   logic                   block_valid;
   logic                   block_ready;

   modport master (
      output block_data,
      output block_valid,
      input  block_ready
   );

   modport slave (
      input  block_data,
      input  block_valid,
      output block_ready
   );
endinterface

// File: rtl/uart_block_tx.sv
// rtl/uart_block_tx.sv - multi-byte block to 8N1 serial transmitter
// Splits an accepted block into bytes and shifts each out LSB first with its own baud timer.
module uart_block_tx #(
   parameter int CLK_HZ    = 100000000,
   parameter int BAUD_RATE = 9600,
   parameter int NUM_BYTES = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic           clk_100MHz,
   input  logic           reset_n,
   uart_block_tx_if.slave blk,
   output logic           tx,
   output logic           busy,
   output logic           byte_done_tick,
   output logic           block_done_tick
);
   localparam int DIV = CLK_HZ / BAUD_RATE;
   localparam int W   = 8 * NUM_BYTES;
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
   localparam logic [BW-1:0] BYTE_LAST = BW'(NUM_BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [2:0]      bit_q, bit_d;
   logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
   logic [W-1:0]    blk_q, blk_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            tx_q, tx_d;
   logic            tick_last;

   // The byte about to be framed always sits at the end of the block register
   // that faces the chosen byte order.
   function automatic logic [7:0] first_byte(input logic [W-1:0] b);
      if (MSB_FIRST) begin
         return b[W-1 -: 8];
      end
      return b[7:0];
   endfunction

   function automatic logic [W-1:0] next_blk(input logic [W-1:0] b);
      if (MSB_FIRST) begin
         return b << 8;
      end
      return b >> 8;
   endfunction

   assign tick_last = (tick_q == TICK_LAST);

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         tick_q     <= '0;
         bit_q      <= '0;
         byte_cnt_q <= '0;
         blk_q      <= '0;
         shreg_q    <= '0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         bit_q      <= bit_d;
         byte_cnt_q <= byte_cnt_d;
         blk_q      <= blk_d;
         shreg_q    <= shreg_d;
         tx_q       <= tx_d;
      end
   end

   // tx_d is the level of the bit that starts on the next edge, so the line
   // changes exactly when the baud timer wraps.
   always_comb begin
      state_d         = state_q;
      tick_d          = '0;
      bit_d           = bit_q;
      byte_cnt_d      = byte_cnt_q;
      blk_d           = blk_q;
      shreg_d         = shreg_q;
      tx_d            = tx_q;
      byte_done_tick  = 1'b0;
      block_done_tick = 1'b0;

      if (state_q != S_IDLE && !tick_last) begin
         tick_d = tick_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (blk.block_valid) begin
               blk_d      = blk.block_data;
               shreg_d    = first_byte(blk.block_data);
               byte_cnt_d = '0;
               bit_d      = '0;
               tx_d       = 1'b0;
               state_d    = S_START;
            end
         end
         S_START: begin
            if (tick_last) begin
               bit_d   = '0;
               tx_d    = shreg_q[0];
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tick_last) begin
               shreg_d = shreg_q >> 1;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shreg_q[1];
               end
            end
         end
         S_STOP: begin
            if (tick_last) begin
               byte_done_tick = 1'b1;
               if (byte_cnt_q == BYTE_LAST) begin
                  block_done_tick = 1'b1;
                  tx_d            = 1'b1;
                  state_d         = S_IDLE;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
                  blk_d      = next_blk(blk_q);
                  shreg_d    = first_byte(next_blk(blk_q));
                  tx_d       = 1'b0;
                  state_d    = S_START;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   assign tx              = tx_q;
   assign busy            = (state_q != S_IDLE);
   assign blk.block_ready = (state_q == S_IDLE);
endmodule

// File: tb/tb_uart_block_tx.sv
// tb/tb_uart_block_tx.sv - bench for uart_block_tx
// Three instances (1 byte, 8 bytes LSB-first, 8 bytes MSB-first) at DIV=10.
module tb_uart_block_tx;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_block_tx_if #(.NUM_BYTES(1)) if_a ();
   uart_block_tx_if #(.NUM_BYTES(8)) if_b ();
   uart_block_tx_if #(.NUM_BYTES(8)) if_c ();

   logic [2:0] tx_o, busy_o, bdt_o, bkt_o, rdy_o, val_o;
   logic [63:0] dat [3];

   uart_block_tx #(.CLK_HZ(100), .BAUD_RATE(10), .NUM_BYTES(1), .MSB_FIRST(1'b0)) dut_a (
      .clk_100MHz(clk), .reset_n(rst_n), .blk(if_a), .tx(tx_o[0]), .busy(busy_o[0]),
      .byte_done_tick(bdt_o[0]), .block_done_tick(bkt_o[0]));
   uart_block_tx #(.CLK_HZ(100), .BAUD_RATE(10), .NUM_BYTES(8), .MSB_FIRST(1'b0)) dut_b (
      .clk_100MHz(clk), .reset_n(rst_n), .blk(if_b), .tx(tx_o[1]), .busy(busy_o[1]),
      .byte_done_tick(bdt_o[1]), .block_done_tick(bkt_o[1]));
   uart_block_tx #(.CLK_HZ(100), .BAUD_RATE(10), .NUM_BYTES(8), .MSB_FIRST(1'b1)) dut_c (
      .clk_100MHz(clk), .reset_n(rst_n), .blk(if_c), .tx(tx_o[2]), .busy(busy_o[2]),
      .byte_done_tick(bdt_o[2]), .block_done_tick(bkt_o[2]));

   assign rdy_o  = {if_c.block_ready, if_b.block_ready, if_a.block_ready};
   assign val_o  = {if_c.block_valid, if_b.block_valid, if_a.block_valid};
   assign dat[0] = {56'd0, if_a.block_data};
   assign dat[1] = if_b.block_data;
   assign dat[2] = if_c.block_data;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int nby(input int d);
      return (d == 0) ? 1 : 8;
   endfunction

   // Level of the line n bit-periods into a block: frame f = n/10, position n%10.
   function automatic logic stream_bit(input int d, input logic [63:0] data, input int n);
      int f, p, bi;
      logic [7:0] by;
      f = n / 10;
      p = n % 10;
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      bi = (d == 2) ? nby(d) - 1 - f : f;
      by = data[8*bi +: 8];
      return by[p-1];
   endfunction

   bit          m_act  [3];
   int          m_k    [3];
   logic [63:0] m_data [3];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 3; d++) begin
            m_act[d] <= 1'b0;
            m_k[d]   <= 0;
         end
      end else begin
         for (int d = 0; d < 3; d++) begin
            if (m_act[d]) begin
               if (m_k[d] == nby(d) * 100 - 1) m_act[d] <= 1'b0;
               else m_k[d] <= m_k[d] + 1;
            end else if (val_o[d]) begin
               m_act[d]  <= 1'b1;
               m_k[d]    <= 0;
               m_data[d] <= dat[d];
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin : per_dut
         logic e_tx, e_bd, e_bk;
         e_tx = m_act[d] ? stream_bit(d, m_data[d], m_k[d] / 10) : 1'b1;
         e_bd = m_act[d] && (m_k[d] % 100 == 99);
         e_bk = m_act[d] && (m_k[d] == nby(d) * 100 - 1);
         chk($sformatf("tx dut%0d k=%0d", d, m_k[d]), 64'(tx_o[d]), 64'(e_tx));
         chk($sformatf("busy dut%0d", d), 64'(busy_o[d]), 64'(m_act[d]));
         chk($sformatf("ready dut%0d", d), 64'(rdy_o[d]), 64'(!m_act[d]));
         chk($sformatf("byte_done dut%0d", d), 64'(bdt_o[d]), 64'(e_bd));
         chk($sformatf("block_done dut%0d", d), 64'(bkt_o[d]), 64'(e_bk));
      end
   end

   bit         rec = 1'b0;
   int         sel = 0;
   logic       txq [$];
   int         bdq [$];
   int         bkq [$];
   logic [7:0] dec_q [$];
   int         first0;

   always @(negedge clk) begin
      if (rec) begin
         if (bdt_o[sel]) bdq.push_back(txq.size());
         if (bkt_o[sel]) bkq.push_back(txq.size());
         txq.push_back(tx_o[sel]);
      end
   end

   task automatic start_rec(input int d);
      txq.delete();
      bdq.delete();
      bkq.delete();
      sel = d;
      rec = 1'b1;
   endtask

   // Line-level receiver: sample each data bit at its centre.
   task automatic decode();
      dec_q.delete();
      first0 = -1;
      for (int i = 0; i < txq.size(); i++) begin
         if (txq[i] == 1'b0 && i + 95 < txq.size()) begin : one_frame
            logic [7:0] b;
            for (int j = 0; j < 8; j++) b[j] = txq[i + 15 + 10*j];
            dec_q.push_back(b);
            if (first0 < 0) first0 = i;
            i += 95;
         end
      end
   endtask

   function automatic logic [63:0] pack(input int from);
      logic [63:0] r = '0;
      for (int j = 0; j < 8; j++)
         if (from + j < dec_q.size()) r = {r[55:0], dec_q[from + j]};
      return r;
   endfunction

   task automatic set_valid(input int d, input logic v, input logic [63:0] data);
      case (d)
         0: begin if_a.block_data = data[7:0]; if_a.block_valid = v; end
         1: begin if_b.block_data = data;      if_b.block_valid = v; end
         default: begin if_c.block_data = data; if_c.block_valid = v; end
      endcase
   endtask

   task automatic send(input int d, input logic [63:0] data);
      @(negedge clk);
      set_valid(d, 1'b1, data);
      @(negedge clk);
      set_valid(d, 1'b0, data);
   endtask

   initial begin
      int n, bad, start2;
      logic [9:0] pat;
      for (int d = 0; d < 3; d++) set_valid(d, 1'b0, 64'd0);
      repeat (3) @(negedge clk);
      chk("reset tx", 64'(tx_o), 64'h7);
      chk("reset ready", 64'(rdy_o), 64'h7);
      chk("reset busy", 64'(busy_o), 64'h0);
      rst_n = 1'b1;

      start_rec(1);
      repeat (50) @(negedge clk);
      rec = 1'b0;
      n = 0;
      foreach (txq[i]) if (txq[i] !== 1'b1) n++;
      chk("idle50 non-high samples", 64'(n), 64'd0);
      chk("idle50 ready", 64'(rdy_o), 64'h7);

      start_rec(0);
      send(0, 64'hA5);
      repeat (110) @(negedge clk);
      rec = 1'b0;
      decode();
      pat = '0;
      for (int p = 0; p < 10; p++) pat = {pat[8:0], txq[first0 + 10*p + 5]};
      chk("A5 frame pattern", 64'(pat), 64'(10'b0101001011));
      chk("A5 byte_done count", 64'(bdq.size()), 64'd1);
      chk("A5 block_done count", 64'(bkq.size()), 64'd1);
      if (bdq.size() > 0) chk("A5 byte_done clock", 64'(bdq[0] - first0 + 1), 64'd100);
      if (bkq.size() > 0) chk("A5 block_done clock", 64'(bkq[0] - first0 + 1), 64'd100);

      start_rec(1);
      send(1, 64'h0123456789ABCDEF);
      repeat (820) @(negedge clk);
      rec = 1'b0;
      decode();
      chk("lsb-first byte stream", pack(0), 64'hEFCDAB8967452301);
      chk("lsb-first byte_done count", 64'(bdq.size()), 64'd8);
      if (bkq.size() > 0) chk("lsb-first block length", 64'(bkq[0] - first0 + 1), 64'd800);
      else chk("lsb-first block_done seen", 64'(bkq.size()), 64'd1);
      bad = 0;
      for (int i = 0; i + 1 < bdq.size(); i++) if (bdq[i+1] - bdq[i] != 100) bad++;
      chk("byte_done spacing errors", 64'(bad), 64'd0);

      start_rec(2);
      send(2, 64'h0123456789ABCDEF);
      repeat (820) @(negedge clk);
      rec = 1'b0;
      decode();
      chk("msb-first byte stream", pack(0), 64'h0123456789ABCDEF);

      start_rec(1);
      @(negedge clk);
      set_valid(1, 1'b1, 64'h1122334455667788);
      @(negedge clk);
      set_valid(1, 1'b1, 64'h99AABBCCDDEEFF00);
      repeat (800) @(negedge clk);
      chk("b2b idle cycle ready", 64'(rdy_o[1]), 64'd1);
      @(negedge clk);
      set_valid(1, 1'b0, 64'd0);
      chk("b2b second accepted", 64'(busy_o[1]), 64'd1);
      repeat (820) @(negedge clk);
      rec = 1'b0;
      decode();
      chk("b2b byte count", 64'(dec_q.size()), 64'd16);
      chk("b2b first block", pack(0), 64'h8877665544332211);
      chk("b2b second block", pack(8), 64'h00FFEEDDCCBBAA99);
      start2 = -1;
      if (bkq.size() > 0)
         for (int i = bkq[0] + 1; i < txq.size() && start2 < 0; i++) if (txq[i] == 1'b0) start2 = i;
      chk("b2b idle gap", 64'(start2 - (bkq.size() > 0 ? bkq[0] : 0) - 1), 64'd1);

      start_rec(1);
      send(1, 64'hDEADBEEFCAFEF00D);
      repeat (349) @(negedge clk);
      chk("mid-block busy", 64'(busy_o[1]), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset tx", 64'(tx_o[1]), 64'd1);
      chk("async reset busy", 64'(busy_o[1]), 64'd0);
      chk("async reset ready", 64'(rdy_o[1]), 64'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      rec = 1'b0;
      chk("no block_done after reset", 64'(bkq.size()), 64'd0);

      start_rec(1);
      send(1, 64'h0F1E2D3C4B5A6978);
      repeat (820) @(negedge clk);
      rec = 1'b0;
      decode();
      chk("post-reset block", pack(0), 64'h78695A4B3C2D1E0F);
      chk("post-reset block_done count", 64'(bkq.size()), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
